alu_op_sequencer: RTL and testbench

//  Parametrised successor to the single-opcode ALU control. Accepts one 6-bit function code per

---
 rtl/alu_op_sequencer.sv | 112 +++++++++++
 tb/tb_alu_op_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Function-code sequencer for the ALU datapath: single-cycle ops pass straight through,
// MULTU/DIVU run for a parametrised number of cycles and finish with a one-cycle HI/LO write.
module alu_op_sequencer #(
  parameter int unsigned       FUNC_W     = 6,
  parameter int unsigned       MUL_CYCLES = 32,
  parameter int unsigned       DIV_CYCLES = 32,
  parameter int unsigned       CNT_W      = 6,
  parameter logic [FUNC_W-1:0] IDLE_CODE  = '0,
  parameter logic [FUNC_W-1:0] HILO_CODE  = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FUNC_W-1:0] func,
  input  logic              flush,
  output logic              ready,
  output logic              busy,
  output logic [FUNC_W-1:0] sig_alu,
  output logic [FUNC_W-1:0] sig_sht,
  output logic [FUNC_W-1:0] sig_mul,
  output logic [FUNC_W-1:0] sig_mux,
  output logic              hilo_we,
  output logic              done
);

  localparam logic [FUNC_W-1:0] MULTU_CODE = FUNC_W'(25);
  localparam logic [FUNC_W-1:0] DIVU_CODE  = FUNC_W'(27);

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    HILO_WB
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FUNC_W-1:0] sig_q, sig_d;
  logic              hilo_we_q, hilo_we_d;
  logic              done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = IDLE_CODE;
    hilo_we_d = 1'b0;
    done_d    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (func == MULTU_CODE) begin
              state_d = MUL_RUN;
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
              sig_d   = MULTU_CODE;
            end else if (func == DIVU_CODE) begin
              state_d = DIV_RUN;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              sig_d   = DIVU_CODE;
            end else begin
              sig_d  = func;
              done_d = 1'b1;
            end
          end
        end
        MUL_RUN, DIV_RUN: begin
          // counter reaching zero marks the last execute cycle; it never wraps
          if (cnt_q == '0) begin
            state_d   = HILO_WB;
            sig_d     = HILO_CODE;
            hilo_we_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            sig_d = (state_q == MUL_RUN) ? MULTU_CODE : DIVU_CODE;
          end
        end
        HILO_WB: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sig_q     <= IDLE_CODE;
      hilo_we_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
      hilo_we_q <= hilo_we_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign sig_alu = sig_q;
  assign sig_sht = sig_q;
  assign sig_mul = sig_q;
  assign sig_mux = sig_q;
  assign hilo_we = hilo_we_q;
  assign done    = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer against a per-cycle output schedule model.
module tb_alu_op_sequencer;

  localparam int unsigned MUL_N = 32;
  localparam int unsigned DIV_N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] func = '0;
  logic       flush = 1'b0;
  logic       ready, busy, hilo_we, done;
  logic [5:0] sig_alu, sig_sht, sig_mul, sig_mux;

  alu_op_sequencer #(
    .FUNC_W    (6),
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W     (6),
    .IDLE_CODE (6'd0),
    .HILO_CODE (6'h3F)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func   (func),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .sig_alu(sig_alu),
    .sig_sht(sig_sht),
    .sig_mul(sig_mul),
    .sig_mux(sig_mux),
    .hilo_we(hilo_we),
    .done   (done)
  );

  always #5 clk = ~clk;

  // One expected output cycle: code on all sig_*, strobes, and whether the unit is occupied.
  typedef struct {
    logic [5:0] sig;
    bit         hw;
    bit         dn;
    bit         bsy;
  } exp_t;

  exp_t cur;
  exp_t sched[$];
  bit   have_exp = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hilo   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] s, input bit hw, input bit dn, input bit bsy);
    exp_t e;
    e.sig = s; e.hw = hw; e.dn = dn; e.bsy = bsy;
    return e;
  endfunction

  // Check the cycle in progress, then drive new inputs and predict the cycle after the next edge.
  task automatic step(input logic r, input logic s, input logic [5:0] f, input logic fl);
    @(negedge clk);
    if (have_exp) begin
      check("sig_alu", 32'(sig_alu), 32'(cur.sig));
      check("sig_sht", 32'(sig_sht), 32'(cur.sig));
      check("sig_mul", 32'(sig_mul), 32'(cur.sig));
      check("sig_mux", 32'(sig_mux), 32'(cur.sig));
      check("hilo_we", 32'(hilo_we), 32'(cur.hw));
      check("done",    32'(done),    32'(cur.dn));
      check("ready",   32'(ready),   32'(!cur.bsy));
      check("busy",    32'(busy),    32'(cur.bsy));
      if (hilo_we === 1'b1) n_hilo++;
    end
    rst_n = r; start = s; func = f; flush = fl;
    if (!r || fl) begin
      sched.delete();
      cur = mk(6'd0, 0, 0, 0);
    end else if (cur.bsy) begin
      cur = (sched.size() > 0) ? sched.pop_front() : mk(6'd0, 0, 0, 0);
    end else if (s && (f == 6'd25 || f == 6'd27)) begin
      cur = mk(f, 0, 0, 1);
      repeat (((f == 6'd25) ? MUL_N : DIV_N) - 1) sched.push_back(mk(f, 0, 0, 1));
      sched.push_back(mk(6'h3F, 1, 1, 1));
    end else if (s) begin
      cur = mk(f, 0, 1, 0);
    end else begin
      cur = mk(6'd0, 0, 0, 0);
    end
    have_exp = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1, 0, 6'd0, 0);
  endtask

  logic [5:0] codes [0:9] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd27, 6'd16, 6'd18};

  initial begin
    int hilo_before;
    logic [5:0] rf;

    // reset
    step(0, 0, 6'd0, 0);
    step(0, 0, 6'd0, 0);
    idle(2);

    // back-to-back single-cycle ops
    step(1, 1, 6'd32, 0);
    step(1, 1, 6'd34, 0);
    idle(3);

    // full-length MULTU, exactly one HI/LO write
    hilo_before = n_hilo;
    step(1, 1, 6'd25, 0);
    idle(MUL_N + 4);
    check("mul_hilo_pulses", 32'(n_hilo - hilo_before), 32'd1);

    // short DIVU with ADD held: accepted only after HILO_WB
    step(1, 1, 6'd27, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 6'd32, 0);
    idle(3);

    // flush mid-MULTU aborts without a HI/LO write
    hilo_before = n_hilo;
    step(1, 1, 6'd25, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 6'd0, 0);
    step(1, 1, 6'd32, 1);
    idle(MUL_N + 4);
    check("flush_no_hilo", 32'(n_hilo - hilo_before), 32'd0);

    // reset during DIV_RUN with start held
    hilo_before = n_hilo;
    step(1, 1, 6'd27, 0);
    step(1, 1, 6'd27, 0);
    step(0, 1, 6'd27, 0);
    idle(DIV_N + 3);
    check("rst_no_hilo", 32'(n_hilo - hilo_before), 32'd0);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rf = ($urandom_range(0, 10) == 10) ? 6'($urandom) : codes[$urandom_range(0, 9)];
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 9) < 6), rf,
           ($urandom_range(0, 49) == 0));
    end
    idle(MUL_N + 4);
    step(1, 0, 6'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
